// File: rtl/k2red_pipe.sv
// k2red_pipe: pipelined K-RED / K^2-RED modular reduction for q = k*2^m + 1,
// k = 2^L1 +/- 2^L2 +/- 2^L3, built from shifts and adds only.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_we, cfg_q..cfg_s3        config load (accepted only when idle)
//   cfg_err                      one-cycle pulse when a config load is rejected
//   busy                         some pipeline stage holds a valid operand
//   valid_in/ready_in, mode_in, c_in, tag_in    operand handshake
//   valid_out/ready_out, t_out, tag_out         result handshake
module k2red_pipe #(
  parameter int unsigned LOGQ   = 32,
  parameter int unsigned LOGL   = 5,
  parameter int unsigned TAGW   = 4,
  parameter int unsigned FF_SHF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LOGQ-1:0]   cfg_q,
  input  logic [LOGL-1:0]   cfg_m,
  input  logic [LOGL-1:0]   cfg_l1,
  input  logic [LOGL-1:0]   cfg_l2,
  input  logic [LOGL-1:0]   cfg_l3,
  input  logic [1:0]        cfg_s2,
  input  logic [1:0]        cfg_s3,
  output logic              cfg_err,
  output logic              busy,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              mode_in,
  input  logic [2*LOGQ-1:0] c_in,
  input  logic [TAGW-1:0]   tag_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [LOGQ-1:0]   t_out,
  output logic [TAGW-1:0]   tag_out
);
  localparam int unsigned CW = 2*LOGQ;
  // Signed datapath: covers C < q^2, shift products and q << (LOGQ+1).
  localparam int unsigned W  = 2*LOGQ + 4;
  // Split point of the final reduction across the two correction stages.
  localparam int unsigned H  = LOGQ / 2;

  typedef logic signed [W-1:0] dat_t;

  // Low m bits of x; always non-negative.
  function automatic dat_t lo_part(input dat_t x, input logic [LOGL-1:0] m);
    dat_t mask;
    mask = (W'(1) << m) - W'(1);
    return x & mask;
  endfunction

  // k*x0 with k = 2^l1 + s2*2^l2 + s3*2^l3; codes 01 add, 11 subtract, else absent.
  function automatic dat_t k_mul(input dat_t x0, input logic [LOGL-1:0] l1,
                                 input logic [LOGL-1:0] l2, input logic [LOGL-1:0] l3,
                                 input logic [1:0] s2, input logic [1:0] s3);
    dat_t acc;
    acc = x0 << l1;
    case (s2)
      2'b01:   acc = acc + (x0 << l2);
      2'b11:   acc = acc - (x0 << l2);
      default: acc = acc;
    endcase
    case (s3)
      2'b01:   acc = acc + (x0 << l3);
      2'b11:   acc = acc - (x0 << l3);
      default: acc = acc;
    endcase
    return acc;
  endfunction

  // Restoring reduction: conditionally subtract q<<j for j = hi_j down to lo_j.
  function automatic dat_t restore(input dat_t v, input logic [LOGQ-1:0] q,
                                   input int hi_j, input int lo_j);
    dat_t r;
    dat_t qs;
    r = v;
    for (int j = int'(LOGQ) + 1; j >= 0; j--) begin
      qs = $signed(W'(q) << j);
      if (j <= hi_j && j >= lo_j && r >= qs) r = r - qs;
    end
    return r;
  endfunction

  // Config registers
  logic [LOGQ-1:0] q_q;
  logic [LOGL-1:0] m_q, l1_q, l2_q, l3_q;
  logic [1:0]      cs2_q, cs3_q;
  logic            cfg_err_q;

  logic en;

  logic            in_v_q, in_m_q;
  logic [TAGW-1:0] in_g_q;
  logic [CW-1:0]   in_c_q;

  logic            a_v, a_m;
  logic [TAGW-1:0] a_g;
  dat_t            a_prod, a_hi, a_x_c, a_prod_c, a_hi_c;

  logic            r1_v_q, r1_m_q;
  logic [TAGW-1:0] r1_g_q;
  dat_t            r1_x_q;

  logic            b_v, b_m;
  logic [TAGW-1:0] b_g;
  dat_t            b_prod, b_hi, b_x, b_prod_c, b_hi_c;

  logic            r2_v_q;
  logic [TAGW-1:0] r2_g_q;
  dat_t            r2_x_q;

  logic            ca_v_q;
  logic [TAGW-1:0] ca_g_q;
  dat_t            ca_x_q, ca_x_d;

  logic            vo_q;
  logic [LOGQ-1:0] t_q;
  logic [TAGW-1:0] tag_q;

  // One global enable: everything advances unless the output is stalled.
  assign en        = !(vo_q && !ready_out);
  assign ready_in  = en;
  assign busy      = in_v_q | a_v | r1_v_q | b_v | r2_v_q | ca_v_q | vo_q;
  assign cfg_err   = cfg_err_q;
  assign valid_out = vo_q;
  assign t_out     = t_q;
  assign tag_out   = tag_q;

  // Config load only into an empty pipe with no operand arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0; m_q <= '0; l1_q <= '0; l2_q <= '0; l3_q <= '0;
      cs2_q <= '0; cs3_q <= '0; cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (busy || valid_in);
      if (cfg_we && !busy && !valid_in) begin
        q_q <= cfg_q; m_q <= cfg_m; l1_q <= cfg_l1; l2_q <= cfg_l2; l3_q <= cfg_l3;
        cs2_q <= cfg_s2; cs3_q <= cfg_s3;
      end
    end
  end

  // Pass-1 split and shift-add product.
  always_comb begin
    a_x_c    = $signed(W'(in_c_q));
    a_prod_c = k_mul(lo_part(a_x_c, m_q), l1_q, l2_q, l3_q, cs2_q, cs3_q);
    a_hi_c   = a_x_c >>> m_q;
  end

  // Pass-2 split and shift-add product, taken from the pass-1 result.
  always_comb begin
    b_prod_c = k_mul(lo_part(r1_x_q, m_q), l1_q, l2_q, l3_q, cs2_q, cs3_q);
    b_hi_c   = r1_x_q >>> m_q;
  end

  if (FF_SHF != 0) begin : g_prod_ff
    always_ff @(posedge clk) begin
      if (rst) begin
        a_v <= 1'b0; a_m <= 1'b0; a_g <= '0; a_prod <= '0; a_hi <= '0;
        b_v <= 1'b0; b_m <= 1'b0; b_g <= '0; b_prod <= '0; b_hi <= '0; b_x <= '0;
      end else if (en) begin
        a_v <= in_v_q; a_m <= in_m_q; a_g <= in_g_q; a_prod <= a_prod_c; a_hi <= a_hi_c;
        b_v <= r1_v_q; b_m <= r1_m_q; b_g <= r1_g_q; b_prod <= b_prod_c; b_hi <= b_hi_c;
        b_x <= r1_x_q;
      end
    end
  end else begin : g_prod_comb
    assign a_v = in_v_q;  assign a_m = in_m_q;  assign a_g = in_g_q;
    assign a_prod = a_prod_c;  assign a_hi = a_hi_c;
    assign b_v = r1_v_q;  assign b_m = r1_m_q;  assign b_g = r1_g_q;
    assign b_prod = b_prod_c;  assign b_hi = b_hi_c;  assign b_x = r1_x_q;
  end

  // First correction half: lift negatives by q<<LOGQ, then strip the high multiples.
  always_comb begin
    ca_x_d = r2_x_q;
    if (ca_x_d < 0) ca_x_d = ca_x_d + $signed(W'(q_q) << LOGQ);
    ca_x_d = restore(ca_x_d, q_q, int'(LOGQ) + 1, int'(H));
  end

  // Main pipeline ranks; mode 0 bypasses pass 2 so both modes share latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_q <= 1'b0; in_m_q <= 1'b0; in_g_q <= '0; in_c_q <= '0;
      r1_v_q <= 1'b0; r1_m_q <= 1'b0; r1_g_q <= '0; r1_x_q <= '0;
      r2_v_q <= 1'b0; r2_g_q <= '0; r2_x_q <= '0;
      ca_v_q <= 1'b0; ca_g_q <= '0; ca_x_q <= '0;
      vo_q   <= 1'b0; t_q <= '0; tag_q <= '0;
    end else if (en) begin
      in_v_q <= valid_in; in_m_q <= mode_in; in_g_q <= tag_in; in_c_q <= c_in;
      r1_v_q <= a_v; r1_m_q <= a_m; r1_g_q <= a_g; r1_x_q <= a_prod - a_hi;
      r2_v_q <= b_v; r2_g_q <= b_g; r2_x_q <= b_m ? (b_prod - b_hi) : b_x;
      ca_v_q <= r2_v_q; ca_g_q <= r2_g_q; ca_x_q <= ca_x_d;
      vo_q   <= ca_v_q;
      t_q    <= ca_v_q ? LOGQ'(restore(ca_x_q, q_q, int'(H) - 1, 0)) : '0;
      tag_q  <= ca_v_q ? ca_g_q : '0;
    end
  end
endmodule

// File: tb/tb_k2red_pipe.sv
// tb_k2red_pipe: directed vectors with a result scoreboard for k2red_pipe.
module tb_k2red_pipe;
  localparam int unsigned LOGQ   = 32;
  localparam int unsigned LOGL   = 5;
  localparam int unsigned TAGW   = 4;
  localparam int unsigned FF_SHF = 1;
  localparam int unsigned LAT    = 4 + 2*FF_SHF;

  localparam logic [63:0] Q64  = 64'd2148794369;
  localparam logic [63:0] QM1  = Q64 - 64'd1;
  localparam logic [63:0] C_SQ = QM1 * QM1;   // (q-1)^2 == 1 mod q
  localparam logic [63:0] C_QQ = Q64 * QM1;   // q*(q-1) == 0 mod q

  logic              clk, rst, cfg_we, cfg_err, busy;
  logic [LOGQ-1:0]   cfg_q;
  logic [LOGL-1:0]   cfg_m, cfg_l1, cfg_l2, cfg_l3;
  logic [1:0]        cfg_s2, cfg_s3;
  logic              valid_in, ready_in, mode_in, valid_out, ready_out;
  logic [2*LOGQ-1:0] c_in;
  logic [TAGW-1:0]   tag_in, tag_out;
  logic [LOGQ-1:0]   t_out;

  typedef struct packed {
    logic [LOGQ-1:0] t;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_seen = 0;

  k2red_pipe #(.LOGQ(LOGQ), .LOGL(LOGL), .TAGW(TAGW), .FF_SHF(FF_SHF)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_m(cfg_m),
    .cfg_l1(cfg_l1), .cfg_l2(cfg_l2), .cfg_l3(cfg_l3), .cfg_s2(cfg_s2), .cfg_s3(cfg_s3),
    .cfg_err(cfg_err), .busy(busy), .valid_in(valid_in), .ready_in(ready_in),
    .mode_in(mode_in), .c_in(c_in), .tag_in(tag_in), .valid_out(valid_out),
    .ready_out(ready_out), .t_out(t_out), .tag_out(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic set_cfg(input logic [LOGL-1:0] l1);
    cfg_q = 32'd2148794369; cfg_m = 5'd17; cfg_l1 = l1; cfg_l2 = 5'd3; cfg_l3 = 5'd1;
    cfg_s2 = 2'b01; cfg_s3 = 2'b01;
  endtask

  task automatic load_cfg();
    set_cfg(5'd14);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Present one operand until accepted; push its expected result at acceptance.
  task automatic drive(input logic md, input logic [63:0] c, input logic [TAGW-1:0] tg,
                       input logic [LOGQ-1:0] expv);
    int guard;
    guard = 0;
    valid_in = 1'b1; mode_in = md; c_in = c; tag_in = tg;
    @(negedge clk);
    while (!ready_in && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!ready_in) begin
      checks++; errors++;
      $display("FAIL accept_timeout got ready_in=0 required 1");
    end else begin
      exp_q.push_back('{t: expv, tag: tg});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid_in = 1'b0; mode_in = 1'b0; c_in = '0; tag_in = '0;
  endtask

  // Called just after the accept edge of a lone operand.
  task automatic wait_lat(input string name);
    int n;
    n = 0;
    while (!valid_out && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(n), 64'(LAT));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((busy || valid_out) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout got busy=%0b required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic single(input logic md, input logic [63:0] c, input logic [TAGW-1:0] tg,
                        input logic [LOGQ-1:0] expv, input string name);
    drive(md, c, tg, expv);
    idle();
    wait_lat(name);
    drain();
  endtask

  // Monitor: scoreboard on every transfer, plus stall and idle-output properties.
  initial begin : monitor
    exp_t            e;
    logic            prev_stall;
    logic [LOGQ-1:0] prev_t;
    logic [TAGW-1:0] prev_tag;
    prev_stall = 1'b0; prev_t = '0; prev_tag = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (valid_out && ready_out) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got t=%0d tag=%0d required no result", t_out, tag_out);
          end else begin
            e = exp_q.pop_front();
            if (t_out !== e.t || tag_out !== e.tag) begin
              errors++;
              $display("FAIL sb_result got t=%0d tag=%0d required t=%0d tag=%0d",
                       t_out, tag_out, e.t, e.tag);
            end
          end
        end
        if (valid_out && !ready_out) begin
          stall_seen++;
          checks++;
          if (ready_in !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_in got %0b required 0", ready_in);
          end
          if (prev_stall) begin
            checks++;
            if (t_out !== prev_t || tag_out !== prev_tag) begin
              errors++;
              $display("FAIL stall_hold got t=%0d tag=%0d required t=%0d tag=%0d",
                       t_out, tag_out, prev_t, prev_tag);
            end
          end
        end
        if (!valid_out) begin
          checks++;
          if (t_out !== '0 || tag_out !== '0) begin
            errors++;
            $display("FAIL idle_zero got t=%0d tag=%0d required 0", t_out, tag_out);
          end
        end
        prev_stall = valid_out && !ready_out;
        prev_t     = t_out;
        prev_tag   = tag_out;
      end
    end
  end

  initial begin : stim
    logic [LOGQ-1:0] st_exp [8];
    int              stall_base;
    int              seen;
    st_exp = '{32'd16394, 32'd537526472, 32'd49182, 32'd1075052944,
               32'd81970, 32'd1612579416, 32'd114758, 32'd1311519};

    rst = 1'b1; cfg_we = 1'b0; set_cfg(5'd0); idle(); ready_out = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_t_out",     64'(t_out),     64'd0);
    check("rst_tag_out",   64'(tag_out),   64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_cfg_err",   64'(cfg_err),   64'd0);
    check("rst_ready_in",  64'(ready_in),  64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    load_cfg();
    @(negedge clk);
    check("cfg_ok_no_err", 64'(cfg_err), 64'd0);
    @(posedge clk); #1;

    // Single operands: value via scoreboard, latency here.
    single(1'b0, 64'd1,                   4'd1,  32'd16394,      "lat_m0_c1");
    single(1'b0, 64'd131072,              4'd2,  32'd2148794368, "lat_m0_c2e17");
    single(1'b1, 64'd1,                   4'd3,  32'd268763236,  "lat_m1_c1");
    single(1'b1, 64'd131072,              4'd4,  32'd2148777975, "lat_m1_c2e17");
    single(1'b1, 64'd2500883870215315764, 4'd5,  32'd1965696994, "lat_m1_big");
    single(1'b0, 64'd0,                   4'd6,  32'd0,          "lat_m0_zero");
    single(1'b1, 64'd0,                   4'd7,  32'd0,          "lat_m1_zero");
    single(1'b0, 64'd131073,              4'd8,  32'd16393,      "lat_m0_c2e17p1");
    single(1'b1, 64'd131073,              4'd9,  32'd268746842,  "lat_m1_c2e17p1");
    single(1'b0, QM1,                     4'd10, 32'd2148777975, "lat_m0_qm1");
    single(1'b1, QM1,                     4'd11, 32'd1880031133, "lat_m1_qm1");
    single(1'b0, Q64,                     4'd12, 32'd0,          "lat_m0_q");
    single(1'b0, C_SQ,                    4'd13, 32'd16394,      "lat_m0_qm1sq");
    single(1'b1, C_SQ,                    4'd14, 32'd268763236,  "lat_m1_qm1sq");
    single(1'b0, C_QQ,                    4'd15, 32'd0,          "lat_m0_qqm1");
    single(1'b1, C_QQ,                    4'd0,  32'd0,          "lat_m1_qqm1");

    // Back-to-back stream, alternating modes, one result per cycle.
    fork
      begin
        for (int i = 0; i < 8; i++) drive(i[0], 64'(i + 1), TAGW'(i), st_exp[i]);
        idle();
      end
      begin
        int n, g;
        n = 0; g = 0;
        while (!valid_out && g < 50) begin g++; @(negedge clk); end
        while (valid_out && n < 20) begin n++; @(negedge clk); end
        check("stream_consecutive", 64'(n), 64'd8);
      end
    join
    drain();

    // Backpressure: ready_out low for three cycles mid-stream.
    stall_base = stall_seen;
    fork
      begin
        for (int i = 0; i < 8; i++) drive(i[0], 64'(i + 1), TAGW'(i + 8), st_exp[i]);
        idle();
      end
      begin
        int g;
        g = 0;
        while (!valid_out && g < 50) begin g++; @(negedge clk); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    drain();
    check("stall_cycles", 64'(stall_seen - stall_base), 64'd3);
    check("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    // Rejected config while busy; results keep the old k.
    drive(1'b0, 64'd1, 4'd5, 32'd16394);
    idle();
    set_cfg(5'd13);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    set_cfg(5'd14);
    @(negedge clk);
    check("cfg_err_pulse", 64'(cfg_err), 64'd1);
    @(negedge clk);
    check("cfg_err_clear", 64'(cfg_err), 64'd0);
    @(posedge clk); #1;
    drain();
    single(1'b1, 64'd2, 4'd6, 32'd537526472, "lat_after_rej");

    // Reset mid-stream: in-flight operands must vanish.
    for (int i = 0; i < 8; i++) drive(i[0], 64'(i + 1), TAGW'(i), st_exp[i]);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid_out", 64'(valid_out), 64'd0);
    check("flush_t_out",     64'(t_out),     64'd0);
    check("flush_busy",      64'(busy),      64'd0);
    check("flush_ready_in",  64'(ready_in),  64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    @(posedge clk); #1;
    load_cfg();
    single(1'b1, 64'd2500883870215315764, 4'd3, 32'd1965696994, "lat_after_rst");

    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/k2red_pipe.md
K2RED_PIPE -- requirements
Module: k2red_pipe

Interface
REQ-001 Parameter LOGQ, default 32: modulus and result width; inputs are 2*LOGQ bits.
REQ-002 Parameter LOGL, default 5: width of each shift-exponent field (m, L1, L2, L3).
REQ-003 Parameter TAGW, default 4: width of the sideband tag carried alongside each operand.
REQ-004 Parameter FF_SHF, default 1: 1 registers each shift-add product (2 extra stages); 0 leaves it combinational.
REQ-005 Ports, in order:
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  cfg_we  in  1  config load strobe.
  cfg_q  in  LOGQ  modulus q = k*2^m + 1.
  cfg_m  in  LOGL  m.
  cfg_l1, cfg_l2, cfg_l3  in  LOGL each  exponents of k.
  cfg_s2, cfg_s3  in  2 each  term code: 00 absent, 01 +, 11 -, 10 reserved (treated as absent).
  cfg_err  out  1  one-cycle pulse when a cfg_we is rejected.
  busy  out  1  high while any pipeline stage holds a valid entry.
  valid_in  in  1  operand valid.
  ready_in  out  1  block accepts the operand this cycle.
  mode_in  in  1  0 = K-RED (k*C mod q), 1 = K^2-RED (k^2*C mod q).
  c_in  in  2*LOGQ  operand C, C < q^2.
  tag_in  in  TAGW  sideband tag.
  valid_out  out  1  result valid.
  ready_out  in  1  downstream accepts the result.
  t_out  out  LOGQ  result.
  tag_out  out  TAGW  tag of that result.

Function
REQ-006 k SHALL equal 2^L1 + s2*2^L2 + s3*2^L3, built only from shifts and adds/subtracts; no multipliers.
REQ-007 Each K-RED pass SHALL split X = X1*2^m + X0 and form k*X0 - X1, with signed intermediates wide enough that no overflow occurs for any C < q^2.
REQ-008 Mode 0 SHALL apply one pass; mode 1 SHALL apply two passes; both SHALL have identical latency.
REQ-009 t_out SHALL be fully reduced to [0, q) by a final correction stage.
REQ-010 Latency SHALL be LAT = 4 + 2*FF_SHF cycles from the accept edge to valid_out, absent stalls.
REQ-011 Transfers: accept when valid_in && ready_in; deliver when valid_out && ready_out.
REQ-012 ready_in SHALL equal !(valid_out && !ready_out); this is one global pipeline enable.
REQ-013 When stalled, every stage SHALL hold its data; t_out and tag_out SHALL remain stable while valid_out is high.
REQ-014 Throughput SHALL be one operand per cycle with ready_out held high; mode_in may change every cycle.
REQ-015 Tag and mode SHALL travel with their operand; results SHALL leave in acceptance order.
REQ-016 cfg_we SHALL load all config registers when busy = 0 and valid_in = 0.
REQ-017 cfg_we SHALL otherwise be ignored, and cfg_err SHALL pulse for one cycle.
REQ-018 Config is used from the cycle after the load; operands accepted on the load cycle are not possible (ready_in irrelevant, valid_in = 0 required).
REQ-019 Config not satisfying q = k*2^m + 1 SHALL give unspecified t_out but correct handshake and latency.
REQ-020 When valid_out = 0, t_out and tag_out SHALL be driven to 0.

Reset
REQ-021 rst SHALL clear all stage valid bits, config registers, valid_out, t_out, tag_out, cfg_err and busy to 0 on the next rising edge.
REQ-022 rst SHALL take priority over cfg_we and valid_in; operands in flight are discarded and no result for them appears.
REQ-023 After rst, ready_in SHALL be 1.

Verification (config q=2148794369, m=17, L1=14, L2=3, L3=1, s2=s3=01, so k=16394; LOGQ=32)
REQ-024 Mode 0, C=1 -> t_out=16394; mode 0, C=131072 -> t_out=2148794368 (q-1), each LAT cycles after accept.
REQ-025 Mode 1, C=1 -> 268763236; mode 1, C=131072 -> 2148777975; mode 1, C=2500883870215315764 -> 1965696994.
REQ-026 Back-to-back stream: 8 operands with alternating modes and tags 0..7 -> results in order with matching tags, one per cycle.
REQ-027 Backpressure: ready_out low for 3 cycles mid-stream -> ready_in low for the same cycles, and no loss, duplication or change of t_out while stalled.
REQ-028 cfg_we while busy -> cfg_err pulses for one cycle and later results still use the old k; rst mid-stream -> valid_out=0 next cycle, and the flushed operands never emerge.
